// File: rtl/sync_fifo_write_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its picker.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Binary index width; a single producer still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo_write_arbiter_if.sv
// Producer handshake plus FIFO write port, named from the arbiter's side.
interface sync_fifo_write_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32
);
  logic [N_REQ-1:0]            req_i;
  logic [N_REQ*DATA_WIDTH-1:0] data_i;
  logic [N_REQ-1:0]            last_i;
  logic [N_REQ-1:0]            ack_o;
  logic                        fifo_full_i;
  logic                        fifo_write_o;
  logic [DATA_WIDTH-1:0]       fifo_wr_data_o;

  // Producers and FIFO side
  modport master (
    output req_i, data_i, last_i, fifo_full_i,
    input  ack_o, fifo_write_o, fifo_wr_data_o
  );

  // Arbiter side
  modport slave (
    input  req_i, data_i, last_i, fifo_full_i,
    output ack_o, fifo_write_o, fifo_wr_data_o
  );
endinterface

// File: rtl/sync_fifo_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after the pointer,
// searching cyclically upward.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int cand;
  int raw;

  // Cyclic scan from the pointer; the first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    raw     = 0;
    for (int i = 0; i < N; i++) begin
      raw  = int'(ptr_i) + i;
      cand = (raw >= N) ? (raw - N) : raw;
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        idx_o         = IDX_W'(cand);
        grant_o[cand] = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ producers.
module sync_fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  sync_fifo_write_arbiter_if.slave      bus,
  output logic [N_REQ-1:0]              grant_o,
  output logic [idx_width(N_REQ)-1:0]   owner_o,
  output logic                          busy_o
);

  localparam int                IDX_W    = idx_width(N_REQ);
  localparam int                CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_REQ - 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;

  logic [N_REQ-1:0]      pick_grant_s;
  logic [IDX_W-1:0]      pick_idx_s;
  logic                  pick_valid_s;
  logic                  own_req_s;
  logic                  own_last_s;
  logic                  xfer_s;
  logic                  cnt_hit_s;
  logic [CNT_W-1:0]      cnt_inc_s;
  logic [DATA_WIDTH-1:0] own_data_s;
  logic [N_REQ-1:0]      ack_s;
  logic                  write_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  rr_priority_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (bus.req_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant_s),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  assign own_req_s  = bus.req_i[owner_q];
  assign own_last_s = bus.last_i[owner_q];
  assign own_data_s = bus.data_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
  // Reset gates the write so an abandoned burst never lands a word.
  assign xfer_s     = (state_q == BURST) && own_req_s && !bus.fifo_full_i && !rst_i;
  assign cnt_inc_s  = cnt_q + CNT_W'(1);
  assign cnt_hit_s  = (cnt_inc_s == CNT_MAX);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d = BURST;
          owner_d = pick_idx_s;
          grant_d = pick_grant_s;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        cnt_d = xfer_s ? cnt_inc_s : cnt_q;
        if (!own_req_s || (xfer_s && (own_last_s || cnt_hit_s))) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);
        end else begin
          state_d = BURST;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    ack_s   = '0;
    write_s = 1'b0;
    wdata_s = '0;
    if (state_q == BURST) begin
      wdata_s = own_data_s;
      if (xfer_s) begin
        ack_s[owner_q] = 1'b1;
        write_s        = 1'b1;
      end else begin
        write_s = 1'b0;
      end
    end else begin
      wdata_s = '0;
    end
  end

  assign bus.ack_o          = ack_s;
  assign bus.fifo_write_o   = write_s;
  assign bus.fifo_wr_data_o = wdata_s;
  assign grant_o            = grant_q;
  assign owner_o            = owner_q;
  assign busy_o             = (state_q == BURST);

endmodule

// File: tb/tb_sync_fifo_write_arbiter.sv
// Randomized and directed bench for sync_fifo_write_arbiter against a behavioural model.
module tb_sync_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] grant;
  logic [1:0]   owner;
  logic         busy;

  sync_fifo_write_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  sync_fifo_write_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus.slave),
    .grant_o (grant),
    .owner_o (owner),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Producer state: quota = words still to send (-1 unlimited), seq = next word number.
  int quota   [N];
  bit last_end[N];
  int seq     [N];
  int exp_seq [N];
  bit rand_mode;
  int wr_count;

  // Model: current grant, pointer, words taken in this burst, arbitrations waited.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;
  int wait_arbs[N];

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bus.req_i[k]              = (quota[k] != 0);
      bus.last_i[k]             = last_end[k] && (quota[k] == 1);
      bus.data_i[k*DW +: DW]    = {8'(k), 24'(seq[k])};
    end
    if (rand_mode) bus.fifo_full_i = ($urandom_range(0, 3) == 0);
  endtask

  task automatic step();
    logic [N-1:0] ack_seen;
    bit           xfer;
    bit           found;
    int           pick;
    int           c;
    int           src;
    drive();
    #1;
    xfer = m_busy && bus.req_i[m_owner] && !bus.fifo_full_i && !rst;
    check_eq("grant", 64'(grant), m_busy ? (64'd1 << m_owner) : 64'd0);
    check_eq("busy", 64'(busy), 64'(m_busy));
    if (m_busy) check_eq("owner", 64'(owner), 64'(m_owner));
    check_eq("ack", 64'(bus.ack_o), xfer ? (64'd1 << m_owner) : 64'd0);
    check_eq("write", 64'(bus.fifo_write_o), 64'(xfer));
    check_eq("wdata", 64'(bus.fifo_wr_data_o),
             m_busy ? 64'({8'(m_owner), 24'(seq[m_owner])}) : 64'd0);
    if (bus.fifo_write_o) begin
      wr_count++;
      src = int'(bus.fifo_wr_data_o[31:24]);
      check_eq("src_range", 64'(src < N), 64'd1);
      if (src < N) begin
        check_eq("order", 64'(bus.fifo_wr_data_o[23:0]), 64'(24'(exp_seq[src])));
        exp_seq[src]++;
      end
    end
    ack_seen = bus.ack_o;

    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_cnt  = 0;
      for (int k = 0; k < N; k++) wait_arbs[k] = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      pick  = 0;
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (!found && bus.req_i[c]) begin
          found = 1'b1;
          pick  = c;
        end
      end
      if (found) begin
        for (int k = 0; k < N; k++) begin
          if (k == pick) wait_arbs[k] = 0;
          else if (bus.req_i[k]) begin
            wait_arbs[k]++;
            check_eq("starve", 64'(wait_arbs[k] < N), 64'd1);
          end
        end
        m_busy  = 1'b1;
        m_owner = pick;
        m_cnt   = 0;
      end
    end else begin
      if (xfer) m_cnt++;
      if (!bus.req_i[m_owner] || (xfer && (bus.last_i[m_owner] || m_cnt == MB))) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end
    end

    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (ack_seen[k]) begin
        seq[k]++;
        if (quota[k] > 0) quota[k]--;
      end
    end
    if (rand_mode) begin
      for (int k = 0; k < N; k++) begin
        if (quota[k] == 0 && $urandom_range(0, 2) == 0) begin
          quota[k]    = $urandom_range(1, 6);
          last_end[k] = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  task automatic set_all(input int q);
    for (int k = 0; k < N; k++) begin
      quota[k]    = q;
      last_end[k] = 1'b0;
    end
  endtask

  task automatic run_to_second_word();
    for (int i = 0; i < 30 && !(m_busy && m_cnt == 1); i++) step();
    check_eq("reach_mid_burst", 64'(m_busy && m_cnt == 1), 64'd1);
  endtask

  initial begin
    rst             = 1'b1;
    rand_mode       = 1'b0;
    wr_count        = 0;
    bus.fifo_full_i = 1'b0;
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    for (int k = 0; k < N; k++) begin
      seq[k] = 0; exp_seq[k] = 0; wait_arbs[k] = 0;
    end
    set_all(0);
    step();
    step();
    check_eq("rst_grant", 64'(grant), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_owner", 64'(owner), 64'd0);
    rst = 1'b0;

    // Single producer: three words, last on the third.
    quota[2]    = 3;
    last_end[2] = 1'b1;
    wr_count    = 0;
    for (int i = 0; i < 6; i++) step();
    check_eq("single_words", 64'(wr_count), 64'd3);
    set_all(-1);
    step();
    check_eq("ptr_after_single", 64'(grant), 64'b1000);

    // Saturated round-robin.
    for (int i = 0; i < 30; i++) step();

    // FIFO full for five cycles mid-burst.
    run_to_second_word();
    bus.fifo_full_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.fifo_full_i = 1'b0;
    for (int i = 0; i < 12; i++) step();

    // Owner drops after one word; next requester after it wins.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_all(0);
    quota[0] = 1;
    quota[2] = -1;
    quota[3] = -1;
    for (int i = 0; i < 4; i++) step();
    check_eq("drop_next_grant", 64'(grant), 64'b0100);

    // Reset during the second word of a burst.
    set_all(-1);
    for (int i = 0; i < 8; i++) step();
    run_to_second_word();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst_grant", 64'(grant), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    step();
    check_eq("midrst_first", 64'(grant), 64'b0001);

    // Random traffic with random backpressure.
    set_all(0);
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
